rs_encode_line_adapter: RTL and testbench

RS_ENCODE_LINE_ADAPTER -- requirements
Module: rs_encode_line_adapter

---
 rtl/rs_encode_line_adapter.sv | 194 +++++++++++++++++++
 tb/tb_rs_encode_line_adapter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encode_line_adapter.sv
// rs_encode_line_adapter
// Splits a block of K data bytes, delivered as DATA_W-bit lines, into a byte
// stream for an external RS encoder. The lines are buffered, and each block's
// last line is tagged with the parity the encoder returns.
// Optional feature macro: RS_ENCODE_LINE_ADAPTER_ZERO_PAD_EN
//   (zeroes the bytes of the last line that lie beyond K).
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. Once valid is raised it stays high with stable data
// until that edge. Ready may depend on state but never on the matching valid.
// The encoder ports (enc_*) have no backpressure.
module rs_encode_line_adapter #(
    parameter int DATA_W    = 64,
    parameter int RS_K_MAX  = 223,
    parameter int NUM_PAR   = 32,
    parameter int OUT_DEPTH = 4,
    localparam int DATA_BYTES = DATA_W / 8,
    localparam int CFG_W      = $clog2(RS_K_MAX + 1),
    localparam int PARITY_W   = 8 * NUM_PAR
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CFG_W-1:0]    cfg_k,
    input  logic                src_line_val,
    input  logic [DATA_W-1:0]   src_line,
    output logic                src_line_rdy,
    output logic                enc_start,
    output logic                enc_sym_val,
    output logic [7:0]          enc_sym,
    input  logic                enc_par_val,
    input  logic [7:0]          enc_par,
    output logic                dst_line_val,
    output logic [DATA_W-1:0]   dst_line,
    output logic [PARITY_W-1:0] dst_parity,
    output logic                dst_last,
    input  logic                dst_line_rdy,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    localparam int BI_W  = $clog2(DATA_BYTES);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PC_W  = $clog2(NUM_PAR + 1);
    localparam int ENT_W = DATA_W + PARITY_W + 1;
    localparam logic [CFG_W-1:0] K_MAX = CFG_W'(RS_K_MAX);

    typedef enum logic [1:0] {IDLE = 2'd0, SER = 2'd1, WAIT_PAR = 2'd2} state_t;

    state_t                state, state_nxt;
    logic                  blk_active;   // a block has started but its last line is not yet buffered
    logic                  first_byte;   // current line is line 0 and byte 0 has not been sent yet
    logic                  last_line;    // line being serialised is the last line of the block
    logic                  init_done;    // keeps src_line_rdy low during reset and one cycle after it
    logic [BI_W-1:0]       byte_idx;
    logic [CFG_W-1:0]      rem;          // block bytes not yet sent on enc_sym
    logic [DATA_W-1:0]     shreg;
    logic [DATA_W-1:0]     held_line;
    logic [PARITY_W-1:0]   par_sr;
    logic [PC_W-1:0]       par_cnt;

    logic [ENT_W-1:0]      mem [OUT_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;

    logic [CFG_W-1:0]      k_new, rem_in;
    logic                  next_is_last, room, line_end, ser_done;
    logic                  par_hit, par_final, accept, push, pop;
    logic [PARITY_W-1:0]   par_next;
    logic [DATA_W-1:0]     held_next;
    logic [ENT_W-1:0]      push_data, head;

    // Input control: effective K, remaining-byte bookkeeping, buffer room, ready and FSM next state
    always_comb begin
        state_nxt = state;
        k_new     = (cfg_k == '0 || cfg_k > K_MAX) ? K_MAX : cfg_k;
        case (state)
            IDLE:    rem_in = blk_active ? rem : k_new;
            SER:     rem_in = rem - 1'b1;
            default: rem_in = rem;
        endcase
        next_is_last = (32'(rem_in) <= DATA_BYTES);
        // A non-last line must leave one entry free for the held last line.
        room = next_is_last ? (count < CNT_W'(OUT_DEPTH)) : (count < CNT_W'(OUT_DEPTH - 1));
        line_end  = (state == SER) && (byte_idx == BI_W'(DATA_BYTES - 1)) && !last_line;
        ser_done  = (state == SER) && last_line && (rem == CFG_W'(1));
        src_line_rdy = init_done && room && ((state == IDLE) || line_end);
        accept    = src_line_val && src_line_rdy;
        par_hit   = (state == WAIT_PAR) && enc_par_val;
        par_final = par_hit && (par_cnt == PC_W'(NUM_PAR - 1));
        par_next  = PARITY_W'({par_sr, enc_par});
        held_next = src_line;
`ifdef RS_ENCODE_LINE_ADAPTER_ZERO_PAD_EN
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i >= int'(rem_in)) held_next[DATA_W-1-8*i -: 8] = 8'h00;
        end
`endif
        case (state)
            IDLE:     if (accept) state_nxt = SER;
            SER:      if (ser_done) state_nxt = WAIT_PAR;
                      else if (line_end && !accept) state_nxt = IDLE;
            WAIT_PAR: if (par_final) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Serialiser, block counters, held last line and parity collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_active <= 1'b0;
            first_byte <= 1'b0;
            last_line  <= 1'b0;
            init_done  <= 1'b0;
            byte_idx   <= '0;
            rem        <= '0;
            shreg      <= '0;
            held_line  <= '0;
            par_sr     <= '0;
            par_cnt    <= '0;
        end else begin
            init_done <= 1'b1;
            if (state == SER) begin
                shreg      <= shreg << 8;
                byte_idx   <= byte_idx + 1'b1;
                rem        <= rem - 1'b1;
                first_byte <= 1'b0;
            end
            if (accept) begin
                shreg      <= src_line;
                byte_idx   <= '0;
                rem        <= rem_in;
                last_line  <= next_is_last;
                first_byte <= !blk_active;
                blk_active <= 1'b1;
                if (next_is_last) held_line <= held_next;
            end
            if (par_hit) begin
                par_sr  <= par_next;
                par_cnt <= par_cnt + 1'b1;
            end
            if (par_final) begin
                par_cnt    <= '0;
                blk_active <= 1'b0;
            end
        end
    end

    // Output buffer control: non-last lines push on accept, the last line pushes with its parity
    always_comb begin
        push      = (accept && !next_is_last) || par_final;
        push_data = par_final ? {held_line, par_next, 1'b1} : {src_line, PARITY_W'(0), 1'b0};
        pop       = dst_line_val && dst_line_rdy;
        head      = mem[rd_ptr];
    end

    // Output buffer pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output buffer storage; contents are only visible while the entry is occupied
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign dst_line_val = (count != '0);
    assign dst_line     = dst_line_val ? head[ENT_W-1 -: DATA_W] : '0;
    assign dst_parity   = dst_line_val ? head[PARITY_W:1] : '0;
    assign dst_last     = dst_line_val & head[0];
    assign enc_sym_val  = (state == SER);
    assign enc_start    = (state == SER) && first_byte;
    assign enc_sym      = (state == SER) ? shreg[DATA_W-1 -: 8] : 8'h00;
    assign busy         = blk_active;
    assign dbg_state    = state;

endmodule

// File: tb/tb_rs_encode_line_adapter.sv
// Bench for rs_encode_line_adapter (DATA_W=32, RS_K_MAX=10, NUM_PAR=4, OUT_DEPTH=4).
// It builds the expected symbol stream and the expected output lines for each
// block directly from K and the byte order. A responder returns the parity
// symbols, and monitors compare the DUT outputs against the expected queues.
module tb_rs_encode_line_adapter;

    localparam int DATA_W    = 32;
    localparam int RS_K_MAX  = 10;
    localparam int NUM_PAR   = 4;
    localparam int OUT_DEPTH = 4;
    localparam int DB        = DATA_W / 8;
    localparam int CFG_W     = 4;
    localparam int PARITY_W  = 8 * NUM_PAR;
    localparam int ENT_W     = DATA_W + PARITY_W + 1;

    logic                clk, rst_n;
    logic [CFG_W-1:0]    cfg_k;
    logic                src_line_val, src_line_rdy;
    logic [DATA_W-1:0]   src_line;
    logic                enc_start, enc_sym_val, enc_par_val;
    logic [7:0]          enc_sym, enc_par;
    logic                dst_line_val, dst_last, dst_line_rdy, busy;
    logic [DATA_W-1:0]   dst_line;
    logic [PARITY_W-1:0] dst_parity;
    logic [1:0]          dbg_state;

    rs_encode_line_adapter #(.DATA_W(DATA_W), .RS_K_MAX(RS_K_MAX), .NUM_PAR(NUM_PAR), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_k(cfg_k),
        .src_line_val(src_line_val), .src_line(src_line), .src_line_rdy(src_line_rdy),
        .enc_start(enc_start), .enc_sym_val(enc_sym_val), .enc_sym(enc_sym),
        .enc_par_val(enc_par_val), .enc_par(enc_par),
        .dst_line_val(dst_line_val), .dst_line(dst_line), .dst_parity(dst_parity),
        .dst_last(dst_last), .dst_line_rdy(dst_line_rdy), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [8:0]       sym_q[$];   // {start, symbol}
    logic [ENT_W-1:0] exp_q[$];   // {line, parity, last}
    int               k_q[$];
    logic [31:0]      bpar_q[$];
    bit               hold_dst = 1'b0;
    bit               sending  = 1'b0;
    int               rx_lines = 0;
    int               sym_total = 0;
    int               start_cyc = 0, end_cyc = 0;
    logic [DATA_W-1:0] last_rx_line = '0;

    function automatic int keff_of(input int cfg);
        return (cfg == 0 || cfg > RS_K_MAX) ? RS_K_MAX : cfg;
    endfunction

    function automatic int nlines_of(input int cfg);
        return (keff_of(cfg) + DB - 1) / DB;
    endfunction

    // ---------------- encoder symbol monitor + parity responder ----------------
    initial begin
        int cur_k, cnt, pdelay, pidx;
        bit pact;
        logic [31:0] cur_par;
        logic [8:0] e;
        enc_par_val = 1'b0; enc_par = 8'h00;
        cur_k = 0; cnt = 0; pdelay = 0; pidx = 0; pact = 1'b0; cur_par = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; cur_k = 0; pact = 1'b0; enc_par_val = 1'b0; enc_par = 8'h00;
                continue;
            end
            enc_par_val = 1'b0;
            enc_par     = 8'($urandom);
            if (pact) begin
                if (pdelay > 0) pdelay--;
                else if (pidx < NUM_PAR) begin
                    enc_par_val = 1'b1;
                    enc_par     = cur_par[31-8*pidx -: 8];
                    pidx++;
                end else begin
                    enc_par_val = 1'b1;   // one surplus symbol that must be ignored
                    pact = 1'b0;
                end
            end else if (enc_sym_val && $urandom_range(0, 3) == 0) begin
                enc_par_val = 1'b1;       // stray parity while serialising
            end
            if (enc_start) begin
                if (k_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL enc_start_unexpected: enc_start=1 with no block pending");
                end else begin
                    cur_k   = k_q.pop_front();
                    cur_par = bpar_q.pop_front();
                end
                cnt = 0;
                start_cyc = cyc;
            end
            if (enc_sym_val) begin
                checks++;
                if (sym_q.size() == 0) begin
                    errors++;
                    $display("FAIL enc_sym_extra: got start=%0b sym=%02h, expected no symbol", enc_start, enc_sym);
                end else begin
                    e = sym_q.pop_front();
                    if ({enc_start, enc_sym} !== e) begin
                        errors++;
                        $display("FAIL enc_sym: got start=%0b sym=%02h, expected start=%0b sym=%02h",
                                 enc_start, enc_sym, e[8], e[7:0]);
                    end
                end
                cnt++;
                sym_total++;
                if (cnt == cur_k) begin
                    pact = 1'b1; pidx = 0; pdelay = $urandom_range(0, 2);
                    end_cyc = cyc;
                end
            end else if (enc_start) begin
                checks++; errors++;
                $display("FAIL enc_start_no_val: enc_start=1 while enc_sym_val=0");
            end
        end
    end

    // ---------------- output line monitor ----------------
    initial begin
        logic [ENT_W-1:0] e, got;
        dst_line_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dst_line_rdy = 1'b0;
                continue;
            end
            dst_line_rdy = hold_dst ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (dst_line_val && dst_line_rdy) begin
                got = {dst_line, dst_parity, dst_last};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dst_extra: got line=%08h par=%08h last=%0b, expected none",
                             dst_line, dst_parity, dst_last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL dst_line: got line=%08h par=%08h last=%0b, expected line=%08h par=%08h last=%0b",
                                 dst_line, dst_parity, dst_last, e[ENT_W-1 -: 32], e[32:1], e[0]);
                    end
                end
                rx_lines++;
                last_rx_line = dst_line;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_line(input logic [31:0] l);
        bit got;
        src_line_val = 1'b1;
        src_line     = l;
        got          = 1'b0;
        for (int n = 0; n < 400; n++) begin
            got = src_line_rdy;
            @(negedge clk);
            if (got) break;
        end
        src_line_val = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL src_accept_timeout: line %08h not accepted, expected accept within 400 cycles", l);
        end
    endtask

    task automatic expect_block(input int cfg, input logic [31:0] l0, l1, l2, input logic [31:0] par);
        logic [31:0] ln[3];
        logic [31:0] last;
        int k, nl;
        ln[0] = l0; ln[1] = l1; ln[2] = l2;
        k  = keff_of(cfg);
        nl = nlines_of(cfg);
        for (int i = 0; i < k; i++) begin
            last = ln[i / DB];
            sym_q.push_back({(i == 0), last[31-8*(i%DB) -: 8]});
        end
        for (int j = 0; j < nl - 1; j++) exp_q.push_back({ln[j], 32'h0, 1'b0});
        last = ln[nl-1];
`ifdef RS_ENCODE_LINE_ADAPTER_ZERO_PAD_EN
        for (int b = k - (nl - 1) * DB; b < DB; b++) last[31-8*b -: 8] = 8'h00;
`endif
        exp_q.push_back({last, par, 1'b1});
        k_q.push_back(k);
        bpar_q.push_back(par);
    endtask

    task automatic send_block(input int cfg, input logic [31:0] l0, l1, l2, input logic [31:0] par);
        logic [31:0] ln[3];
        int nl;
        ln[0] = l0; ln[1] = l1; ln[2] = l2;
        nl = nlines_of(cfg);
        expect_block(cfg, l0, l1, l2, par);
        cfg_k = CFG_W'(cfg);
        for (int j = 0; j < nl; j++) begin
            send_line(ln[j]);
            if (j == 0) cfg_k = CFG_W'($urandom);  // must be ignored for the rest of the block
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0 && sym_q.size() == 0 && !sending) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d lines and %0d symbols outstanding, expected 0", exp_q.size(), sym_q.size());
        end
        checks++;
        if ({busy, dst_line_val} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_drain: busy=%0b dst_line_val=%0b, expected 0 0", busy, dst_line_val);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; src_line_val = 1'b0; src_line = '0; cfg_k = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_line_rdy, enc_start, enc_sym_val, enc_sym, dst_line_val, dst_line, dst_parity, dst_last, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%0b start=%0b symval=%0b sym=%02h dval=%0b line=%08h par=%08h last=%0b busy=%0b, expected all 0",
                     src_line_rdy, enc_start, enc_sym_val, enc_sym, dst_line_val, dst_line, dst_parity, dst_last, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({src_line_rdy, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: src_line_rdy=%0b busy=%0b, expected 1 0", src_line_rdy, busy);
        end
    endtask

    task automatic test_basic();
        int rx0;
        rx0 = rx_lines;
        send_block(10, 32'h00010203, 32'h04050607, 32'h0809AABB, 32'hA1A2A3A4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%0b, expected 1 during last line", busy);
        end
        drain(300);
        checks++;
        if (end_cyc - start_cyc !== 9) begin
            errors++;
            $display("FAIL basic_sym_span: 10 symbols took %0d cycles, expected 10", end_cyc - start_cyc + 1);
        end
        checks++;
        if (rx_lines - rx0 !== 3) begin
            errors++;
            $display("FAIL basic_lines: got %0d lines, expected 3", rx_lines - rx0);
        end
    endtask

    task automatic test_k8();
        int rx0, s0;
        rx0 = rx_lines; s0 = sym_total;
        send_block(8, $urandom, $urandom, $urandom, $urandom);
        drain(300);
        checks++;
        if ({rx_lines - rx0, sym_total - s0} !== {32'd2, 32'd8}) begin
            errors++;
            $display("FAIL k8_counts: got %0d lines %0d symbols, expected 2 lines 8 symbols", rx_lines - rx0, sym_total - s0);
        end
    endtask

    task automatic test_zero_pad();
        logic [31:0] want;
`ifdef RS_ENCODE_LINE_ADAPTER_ZERO_PAD_EN
        want = 32'hDEAD0000;
`else
        want = 32'hDEADBEEF;
`endif
        send_block(10, $urandom, $urandom, 32'hDEADBEEF, $urandom);
        drain(300);
        checks++;
        if (last_rx_line !== want) begin
            errors++;
            $display("FAIL zero_pad_last: got %08h, expected %08h", last_rx_line, want);
        end
    endtask

    task automatic test_cfg_clamp();
        int rx0, s0, cfgs[2];
        cfgs[0] = 0; cfgs[1] = 15;
        for (int c = 0; c < 2; c++) begin
            rx0 = rx_lines; s0 = sym_total;
            send_block(cfgs[c], $urandom, $urandom, $urandom, $urandom);
            drain(300);
            checks++;
            if ({rx_lines - rx0, sym_total - s0} !== {32'd3, 32'd10}) begin
                errors++;
                $display("FAIL cfg_clamp_%0d: got %0d lines %0d symbols, expected 3 lines 10 symbols",
                         cfgs[c], rx_lines - rx0, sym_total - s0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rx0, total, stall_run;
        bit stalled;
        int cfg_list[5];
        rx0 = rx_lines; total = 0;
        for (int b = 0; b < 5; b++) begin
            cfg_list[b] = $urandom_range(5, 12);
            total += nlines_of(cfg_list[b]);
        end
        hold_dst = 1'b1;
        @(negedge clk);
        sending = 1'b1;
        fork
            begin
                for (int b = 0; b < 5; b++) send_block(cfg_list[b], $urandom, $urandom, $urandom, $urandom);
                sending = 1'b0;
            end
        join_none
        stalled = 1'b0; stall_run = 0;
        for (int n = 0; n < 300 && !stalled; n++) begin
            @(negedge clk);
            if (src_line_val && !src_line_rdy) stall_run++;
            else stall_run = 0;
            if (stall_run >= 12) stalled = 1'b1;
        end
        checks++;
        if (!stalled) begin
            errors++;
            $display("FAIL b2b_stall: src_line_rdy never held low with output blocked, expected stall");
        end
        checks++;
        if ({dst_line_val, rx_lines - rx0} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL b2b_hold: dst_line_val=%0b popped=%0d, expected 1 and 0", dst_line_val, rx_lines - rx0);
        end
        hold_dst = 1'b0;
        drain(3000);
        checks++;
        if (rx_lines - rx0 !== total) begin
            errors++;
            $display("FAIL b2b_count: got %0d lines, expected %0d", rx_lines - rx0, total);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) send_block($urandom_range(0, 15), $urandom, $urandom, $urandom, $urandom);
        drain(2000);
    endtask

    task automatic test_reset_mid();
        expect_block(10, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h01020304);
        cfg_k = 4'd10;
        send_line(32'h11223344);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({src_line_rdy, enc_start, enc_sym_val, enc_sym, dst_line_val, dst_line, dst_parity, dst_last, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rdy=%0b start=%0b symval=%0b sym=%02h dval=%0b line=%08h last=%0b busy=%0b, expected all 0",
                     src_line_rdy, enc_start, enc_sym_val, enc_sym, dst_line_val, dst_line, dst_last, busy);
        end
        sym_q.delete(); exp_q.delete(); k_q.delete(); bpar_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_block(10, 32'hCAFEF00D, 32'h0BADBEEF, 32'h12345678, 32'hB1B2B3B4);
        drain(300);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_k8();
        test_zero_pad();
        test_cfg_clamp();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
